// File: rtl/imem_loader.sv
// imem_loader -- boot-time instruction memory writer.
//
// Accepts a length-prefixed byte stream (LEN_LO, LEN_HI, then 4*N payload
// bytes, least-significant byte of each word first). It assembles 32-bit
// words and writes each one through a single-cycle write port. The core is
// held in reset (o_cpu_hold=1) until a complete, valid image has been loaded.
//
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing
// 8-bit modular sum of all payload bytes. A mismatch aborts the load.
//
// Ports:
//   i_clk         clock, all logic on the rising edge
//   i_rst         synchronous, active-high reset
//   i_start       one-cycle pulse that begins a load (from IDLE, DONE or ERR)
//   i_byte_valid  i_byte_data is valid
//   i_byte_data   stream byte
//   o_byte_ready  the loader accepts a byte this cycle
//   o_we          write strobe, one cycle per word
//   o_waddr       word address = BASE_ADDRESS + word index
//   o_wdata       assembled instruction word
//   o_cpu_hold    keeps the core in reset while high
//   o_done        image loaded successfully
//   o_error       load aborted
module imem_loader #(
    parameter int               SIZE         = 32,
    parameter logic [SIZE-1:0]  BASE_ADDRESS = '0,
    parameter int               mem_SIZE     = 256
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic            i_byte_valid,
    input  logic [7:0]      i_byte_data,
    output logic            o_byte_ready,
    output logic            o_we,
    output logic [SIZE-1:0] o_waddr,
    output logic [SIZE-1:0] o_wdata,
    output logic            o_cpu_hold,
    output logic            o_done,
    output logic            o_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_DONE,
        S_ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
        , S_CHK
`endif
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    state_t          w_fin_state;
    logic            r_byte_ready;
    logic            r_we;
    logic [SIZE-1:0] r_waddr;
    logic [SIZE-1:0] r_wdata;
    logic            r_cpu_hold;
    logic            r_done;
    logic            r_error;
    logic [7:0]      r_len_lo;
    logic [15:0]     r_len;
    logic [1:0]      r_lane;
    logic [15:0]     r_word_idx;
    logic [23:0]     r_partial;

    logic            w_accept;
    logic [15:0]     w_len_full;
    logic            w_last_word;
    logic            w_enter_len0;
    logic            w_data_byte;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]      r_sum;
`endif

    assign w_accept     = i_byte_valid && r_byte_ready;
    assign w_len_full   = {i_byte_data, r_len_lo};
    // r_len is at least 1 whenever DATA is active, so r_len - 1 cannot wrap.
    assign w_last_word  = (r_lane == 2'd3) && (r_word_idx == r_len - 16'd1);
    assign w_enter_len0 = (w_state_next == S_LEN0) && (r_state != S_LEN0);
    assign w_data_byte  = w_accept && (r_state == S_DATA);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
`ifdef IMEM_LOADER_CHECKSUM_EN
        w_fin_state  = S_CHK;
`else
        w_fin_state  = S_DONE;
`endif
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (i_start) w_state_next = S_LEN0;
            end
            S_LEN0: begin
                if (w_accept) w_state_next = S_LEN1;
            end
            S_LEN1: begin
                if (w_accept) begin
                    if (32'(w_len_full) > 32'(mem_SIZE)) w_state_next = S_ERR;
                    else if (w_len_full == 16'd0)        w_state_next = w_fin_state;
                    else                                 w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_accept && w_last_word) w_state_next = w_fin_state;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (w_accept) w_state_next = (i_byte_data == r_sum) ? S_DONE : S_ERR;
            end
`endif
            default: w_state_next = S_IDLE;
        endcase
    end

    // Lanes 0..2 of the word under assembly; lane 3 goes straight to r_wdata.
    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_partial[8*gi +: 8] <= 8'h00;
            end else if (w_data_byte && (r_lane == 2'(gi))) begin
                r_partial[8*gi +: 8] <= i_byte_data;
            end
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_byte_ready <= 1'b0;
            r_we         <= 1'b0;
            r_waddr      <= BASE_ADDRESS;
            r_wdata      <= '0;
            r_cpu_hold   <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_len_lo     <= 8'h00;
            r_len        <= 16'h0000;
            r_lane       <= 2'd0;
            r_word_idx   <= 16'h0000;
        end else begin
            // byte_ready follows the state being entered, so it is high in
            // the first cycle of LEN0/LEN1/DATA/CHK with no bubble.
            r_byte_ready <= (w_state_next == S_LEN0) || (w_state_next == S_LEN1) ||
`ifdef IMEM_LOADER_CHECKSUM_EN
                            (w_state_next == S_CHK) ||
`endif
                            (w_state_next == S_DATA);
            r_we <= 1'b0;

            if (w_enter_len0) begin
                r_lane     <= 2'd0;
                r_word_idx <= 16'h0000;
                r_done     <= 1'b0;
                r_error    <= 1'b0;
                r_cpu_hold <= 1'b1;
            end
            if ((w_state_next == S_DONE) && (r_state != S_DONE)) begin
                r_done     <= 1'b1;
                r_cpu_hold <= 1'b0;
            end
            if ((w_state_next == S_ERR) && (r_state != S_ERR)) begin
                r_error    <= 1'b1;
                r_cpu_hold <= 1'b1;
            end

            if (w_accept && (r_state == S_LEN0)) r_len_lo <= i_byte_data;
            if (w_accept && (r_state == S_LEN1)) r_len    <= w_len_full;

            if (w_data_byte) begin
                r_lane <= r_lane + 2'd1;
                if (r_lane == 2'd3) begin
                    r_wdata    <= SIZE'({i_byte_data, r_partial});
                    r_waddr    <= BASE_ADDRESS + SIZE'(r_word_idx);
                    r_we       <= 1'b1;
                    r_word_idx <= r_word_idx + 16'd1;
                end
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running 8-bit sum of payload bytes only.
    always_ff @(posedge i_clk) begin
        if (i_rst || w_enter_len0) begin
            r_sum <= 8'h00;
        end else if (w_data_byte) begin
            r_sum <= r_sum + i_byte_data;
        end
    end
`endif

    assign o_byte_ready = r_byte_ready;
    assign o_we         = r_we;
    assign o_waddr      = r_waddr;
    assign o_wdata      = r_wdata;
    assign o_cpu_hold   = r_cpu_hold;
    assign o_done       = r_done;
    assign o_error      = r_error;

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory. Accepts a length-prefixed byte stream over a valid/ready handshake and assembles little-endian 32-bit words. Writes them through a single-cycle write port into the instruction memory that the fetch stage reads, and holds the core in reset until a complete, valid image has been loaded.

## Interface
- SIZE, 32, width of write address and write data
- BASE_ADDRESS, 32'h00000000, address of word 0; write address = BASE_ADDRESS + word index
- mem_SIZE, 256, capacity in words; a longer image is rejected
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse that begins a load
- byte_valid  in  1  byte_data is valid
- byte_data  in  8  stream byte
- byte_ready  out  1  loader accepts a byte this cycle
- we  out  1  instruction-memory write strobe, one cycle per word
- waddr  out  SIZE  word address for the write
- wdata  out  SIZE  assembled instruction word
- cpu_hold  out  1  keeps the core in reset while high
- done  out  1  image loaded successfully
- error  out  1  load aborted

## Operation
- Stream format:
  - LEN_LO, LEN_HI: 16-bit word count N, little-endian.
  - 4·N payload bytes, least-significant byte of each word first.
  - A checksum byte, only when the checksum feature is compiled in (see Configuration).
- A byte is accepted when byte_valid && byte_ready on a rising edge.
- States and behaviour:
  - IDLE: byte_ready=0. start → LEN0.
  - LEN0: byte_ready=1. Accept LEN_LO → LEN1.
  - LEN1: byte_ready=1. Accept LEN_HI, then:
    - N > mem_SIZE → ERR.
    - N == 0 → DONE, or CHK if the checksum feature is enabled.
    - otherwise → DATA.
  - DATA: byte_ready=1.
    - A 2-bit lane counter places byte k in bits [8k+7:8k].
    - On the 4th byte: wdata and waddr are registered, and we is pulsed on the following cycle.
    - The word index increments, and the lane counter wraps 3→0.
    - After word N−1 is accepted → DONE, or CHK if enabled.
  - CHK: byte_ready=1. Accept one byte; equal to the running sum → DONE, otherwise → ERR.
  - DONE: done=1, cpu_hold=0, byte_ready=0. start → LEN0.
  - ERR: error=1, cpu_hold=1, byte_ready=0. start → LEN0.
- On every transition into LEN0: the word index, lane counter and sum are cleared, and done, error and cpu_hold are reset to 0, 0, 1.
- start is ignored in LEN0, LEN1, DATA and CHK.
- Bytes offered while byte_ready=0 are not consumed. The upstream source holds them.
- waddr arithmetic is SIZE-bit modular. The word index is 16 bits wide; it never exceeds mem_SIZE−1 because N is bounded at LEN1.

## Timing
- Reset values: state=IDLE, byte_ready=0, we=0, waddr=BASE_ADDRESS, wdata=0, cpu_hold=1, done=0, error=0.
- rst in any state, including mid-word, discards the partial word and returns to reset values on the next edge. No we pulse follows the reset.
- byte_ready is a registered function of state. It is high in the cycle the state is entered.
- Back-to-back bytes are accepted at one per cycle with no bubbles.
- Write latency: we rises exactly 1 cycle after the 4th byte of a word is accepted. It is high for 1 cycle, with waddr and wdata stable during it.
- The final word's we pulse coincides with the first cycle of DONE or CHK.
- Minimum load time without checksum: 2 + 4N cycles from the first accepted byte to done=1 (the final state change lands together with the last write).
- done, error and cpu_hold change on the edge that enters DONE, ERR or LEN0.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - An 8-bit modular sum of all payload bytes (length bytes excluded) is accumulated.
  - The trailing checksum byte is required and checked in CHK; a mismatch → ERR.
  - Words already written on a mismatch remain in memory, but cpu_hold stays 1.
- Undefined:
  - The CHK state and the sum register are absent.
  - The last payload byte leads directly to DONE.
  - No trailing byte is expected; any further byte sees byte_ready=0.

## Test plan
- Basic load: start, then stream 02 00 13 00 00 00 93 00 10 00 → two we pulses:
  - waddr=0, wdata=0x00000013
  - waddr=1, wdata=0x00100093
  - then done=1 and cpu_hold=0.
- Backpressure/idle gaps: the same image with byte_valid toggling randomly → identical writes and no dropped or duplicated bytes. byte_ready=0 in IDLE while byte_valid=1 → nothing consumed.
- Oversize image: length 01 01 (257) with mem_SIZE=256 → ERR after LEN_HI, error=1, no we pulse, cpu_hold=1.
- Zero length: 00 00 → DONE with no we pulse (IMEM_LOADER_CHECKSUM_EN: after checksum byte 00).
- Reset mid-word: rst after 2 payload bytes → all outputs at reset values next cycle and no we. A fresh start plus the basic image then loads correctly.
- Checksum (IMEM_LOADER_CHECKSUM_EN): the basic image plus trailer 0xB6 → done=1. The basic image plus trailer 0xB7 → error=1, cpu_hold=1, and both words already written.
